expr_eval: RTL

Downstream companion to the single-digit expression recognizer: consumes the same ASCII character stream, one character per accepted cycle, and evaluates it as an arithmetic expression of single decimal digits joined by `+` and `*`. Standard precedence applies: `*` binds tighter than `+`. It reports the running value of the longest valid prefix, a well-formed flag equivalent to the recognizer's `out`, and sticky error and overflow flags. It sits after the character source, in parallel with or in place of the recognizer, and feeds result display/compare logic.

---
 rtl/expr_pkg.sv | 21 ++
 rtl/expr_eval_if.sv | 14 +
 rtl/char_class.sv | 18 +
 rtl/expr_eval.sv | 125 ++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared constants and enums for the single-digit +/* expression evaluator.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'd48;
  localparam logic [7:0] CH_9    = 8'd57;
  localparam logic [7:0] CH_PLUS = 8'd43;
  localparam logic [7:0] CH_MUL  = 8'd42;

  typedef enum logic [1:0] {
    S_START,
    S_NUM,
    S_OP,
    S_ERR
  } state_e;

  typedef enum logic {
    ADD,
    MUL
  } op_e;

endpackage

// File: rtl/expr_eval_if.sv
// Character stream in, evaluation result out; the evaluator takes the slave side.
interface expr_eval_if #(
  parameter int W = 16
);
  logic [7:0]   in;
  logic         in_valid;
  logic [W-1:0] value;
  logic         ok;
  logic         err;
  logic         ovf;

  modport master (output in, in_valid, input value, ok, err, ovf);
  modport slave  (input in, in_valid, output value, ok, err, ovf);
endinterface

// File: rtl/char_class.sv
// Combinational ASCII decoder: digit / '+' / '*' classification and digit value.
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_mul,
  output logic [3:0] digit
);
  logic [7:0] off;

  assign off      = ch - CH_0;
  assign is_digit = (ch >= CH_0) && (ch <= CH_9);
  assign is_plus  = (ch == CH_PLUS);
  assign is_mul   = (ch == CH_MUL);
  assign digit    = is_digit ? off[3:0] : 4'd0;
endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for digit (op digit)* with '*' binding tighter than '+'.
// value is always sum + term, so a '+' can fold value_q straight into sum.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input logic        clk,
  input logic        clr_n,
  expr_eval_if.slave bus
);
  logic         is_digit, is_plus, is_mul;
  logic [3:0]   digit;
  logic [W-1:0] digit_w;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic [W-1:0] value_q, value_d;
  logic         ovf_q, ovf_d;

  logic [W+3:0] prod;
  logic [W:0]   add;
  logic         legal;
  logic         mul_ovf;

  char_class u_char_class (
    .ch       (bus.in),
    .is_digit (is_digit),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .digit    (digit)
  );

  assign digit_w = {{(W-4){1'b0}}, digit};
  assign prod    = {4'b0, term_q} * {{W{1'b0}}, digit};

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sum_d   = sum_q;
    term_d  = term_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    legal   = 1'b0;
    mul_ovf = 1'b0;

    if (bus.in_valid) begin
      unique case (state_q)
        S_START: begin
          if (is_digit) begin
            sum_d   = '0;
            term_d  = digit_w;
            state_d = S_NUM;
            legal   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_OP: begin
          if (is_digit) begin
            if (op_q == MUL) begin
              term_d  = prod[W-1:0];
              mul_ovf = |prod[W+3:W];
            end else begin
              term_d = digit_w;
            end
            state_d = S_NUM;
            legal   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_plus) begin
            sum_d   = value_q;
            term_d  = '0;
            op_d    = ADD;
            state_d = S_OP;
            legal   = 1'b1;
          end else if (is_mul) begin
            op_d    = MUL;
            state_d = S_OP;
            legal   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        default: ;
      endcase
    end

    add = {1'b0, sum_d} + {1'b0, term_d};
    if (legal) begin
      value_d = add[W-1:0];
      ovf_d   = ovf_q | add[W] | mul_ovf;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_START;
      op_q    <= ADD;
      sum_q   <= '0;
      term_q  <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
      term_q  <= term_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.value = value_q;
  assign bus.ok    = (state_q == S_NUM);
  assign bus.err   = (state_q == S_ERR);
  assign bus.ovf   = ovf_q;
endmodule
